seg_scan_driver: RTL and testbench

- Time-multiplexed driver for an N-digit common-anode/cathode 7-segment display.
- Snapshots a packed hex-digit vector once per frame, scans one digit per slot, and drives a shared segment bus plus one common line per digit.
- Includes a dead-time blank between digits to suppress ghosting.
- Sits between the datapath/BCD counters and the board display pins.

---
 rtl/seg_pkg.sv | 22 ++
 rtl/seg_hex_enc.sv | 13 +
 rtl/seg_scan_driver.sv | 151 +++++++++++++++
 tb/tb_seg_scan_driver.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan driver: glyph table, FSM encoding
// and counter-width helper.
package seg_pkg;

    localparam logic [7:0] SEG_OFF = 8'h00;

    // Active-high glyphs {a,b,c,d,e,f,g,dp}; dp bit is always 0 here
    localparam logic [7:0] SEG_HEX [16] = '{
        8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
        8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
    };

    typedef enum logic {
        ST_DEAD = 1'b0,
        ST_SHOW = 1'b1
    } seg_state_e;

    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg_hex_enc.sv
// Combinational hex-to-7-segment lookup (segments a..g only, no dp).
module seg_hex_enc
    import seg_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    logic glyph_dp_unused;

    assign {seg_o, glyph_dp_unused} = SEG_HEX[hex_i];

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver with per-frame input snapshot and
// dead-time blanking. Optional leading-zero blanking under SEG_LEADING_ZERO_BLANK_EN.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 8,
    parameter int SCAN_DIV       = 10000,
    parameter int DEAD_CYCLES    = 2,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int COM_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic                    lzb_en,
    output logic [7:0]              seg_data,
    output logic [NUM_DIGITS-1:0]   seg_com,
    output logic                    frame_tick
);

    localparam int CNT_W = cnt_width(SCAN_DIV);
    localparam int IDX_W = cnt_width(NUM_DIGITS);

    localparam logic [7:0]            SEG_IDLE = (SEG_ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;
    localparam logic [NUM_DIGITS-1:0] COM_IDLE = {NUM_DIGITS{COM_ACTIVE_LOW != 0}};

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    seg_state_e              state_q, state_d;
    logic                    cnt_last, snapshot;

    logic [4*NUM_DIGITS-1:0] digits_q, digits_v;
    logic [NUM_DIGITS-1:0]   dp_q, dp_v;
    logic [NUM_DIGITS-1:0]   blank_q, blank_v;

    logic [7:0]              seg_data_q, seg_data_d;
    logic [NUM_DIGITS-1:0]   seg_com_q, seg_com_d;
    logic                    frame_tick_q, frame_tick_d;

    logic [3:0]              digit_sel;
    logic [6:0]              glyph7;
    logic [7:0]              seg_raw;
    logic [NUM_DIGITS-1:0]   com_onehot;

    assign cnt_last = (cnt_q == CNT_W'(SCAN_DIV - 1));
    assign snapshot = (idx_q == '0) && (cnt_q == '0);

    // The slot being computed may be the first one after a snapshot edge, so
    // read the values the shadow registers are about to hold.
    assign digits_v = snapshot ? digits : digits_q;
    assign dp_v     = snapshot ? dp     : dp_q;
    assign blank_v  = snapshot ? blank  : blank_q;

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lzb_mask_q, lzb_mask_d, lzb_mask_v;
    logic                  lzb_run;

    always_comb begin
        lzb_mask_d = '0;
        lzb_run    = lzb_en;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            if (digits[4*k +: 4] != 4'h0) lzb_run = 1'b0;
            lzb_mask_d[k] = lzb_run;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        lzb_mask_q <= '0;
        else if (snapshot) lzb_mask_q <= lzb_mask_d;
    end

    assign lzb_mask_v = snapshot ? lzb_mask_d : lzb_mask_q;
`else
    logic lzb_unused;
    assign lzb_unused = lzb_en;
`endif

    // Next-state: counters and the count-driven FSM
    always_comb begin
        cnt_d   = cnt_last ? '0 : cnt_q + 1'b1;
        idx_d   = idx_q;
        state_d = state_q;
        if (cnt_last) idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        case (state_q)
            ST_DEAD: if (cnt_d == CNT_W'(DEAD_CYCLES)) state_d = ST_SHOW;
            ST_SHOW: if (cnt_last)                     state_d = ST_DEAD;
            default:                                   state_d = ST_DEAD;
        endcase
    end

    assign digit_sel = digits_v[4*idx_d +: 4];

    seg_hex_enc u_hex_enc (
        .hex_i (digit_sel),
        .seg_o (glyph7)
    );

    // Outputs are computed from next-state so they register on the same edge
    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    always_comb begin
        seg_raw    = SEG_OFF;
        com_onehot = '0;
        if (state_d == ST_SHOW) begin
            com_onehot[idx_d] = 1'b1;
            if (!blank_v[idx_d]) begin
                seg_raw = {glyph7, dp_v[idx_d]};
`ifdef SEG_LEADING_ZERO_BLANK_EN
                if (lzb_mask_v[idx_d]) seg_raw = {7'b0, dp_v[idx_d]};
`endif
            end
        end
        seg_data_d   = (SEG_ACTIVE_LOW != 0) ? ~seg_raw    : seg_raw;
        seg_com_d    = (COM_ACTIVE_LOW != 0) ? ~com_onehot : com_onehot;
        frame_tick_d = (idx_d == IDX_W'(NUM_DIGITS - 1)) && (cnt_d == CNT_W'(SCAN_DIV - 1));
    end

    // NOTE: all state updates use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            state_q      <= ST_DEAD;
            digits_q     <= '0;
            dp_q         <= '0;
            blank_q      <= '0;
            seg_data_q   <= SEG_IDLE;
            seg_com_q    <= COM_IDLE;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            state_q      <= state_d;
            seg_data_q   <= seg_data_d;
            seg_com_q    <= seg_com_d;
            frame_tick_q <= frame_tick_d;
            if (snapshot) begin
                digits_q <= digits;
                dp_q     <= dp;
                blank_q  <= blank;
            end
        end
    end

    assign seg_data   = seg_data_q;
    assign seg_com    = seg_com_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized self-checking bench for seg_scan_driver against a cycle-indexed
// reference model (N=4, SCAN_DIV=8, DEAD_CYCLES=2, common active-low).
module tb_seg_scan_driver;

    localparam int N     = 4;
    localparam int DIV   = 8;
    localparam int DEAD  = 2;
    localparam int FRAME = N * DIV;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic [15:0] digits = '0;
    logic [3:0]  dp     = '0;
    logic [3:0]  blank  = '0;
    logic        lzb_en = 1'b0;
    logic [7:0]  seg_data;
    logic [3:0]  seg_com;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;
    int t      = 0;

    logic [15:0] s_digits;
    logic [3:0]  s_dp, s_blank;
    logic        s_lzb;

    logic [7:0] glyph [16] = '{
        8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
        8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
    };

    seg_scan_driver #(
        .NUM_DIGITS     (N),
        .SCAN_DIV       (DIV),
        .DEAD_CYCLES    (DEAD),
        .SEG_ACTIVE_LOW (0),
        .COM_ACTIVE_LOW (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digits     (digits),
        .dp         (dp),
        .blank      (blank),
        .lzb_en     (lzb_en),
        .seg_data   (seg_data),
        .seg_com    (seg_com),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
        end
    endtask

    task automatic check_dark(input string tag);
        check({tag, "_seg"},  seg_data,   32'h00);
        check({tag, "_com"},  seg_com,    32'hF);
        check({tag, "_tick"}, frame_tick, 32'h0);
    endtask

    // Checks the outputs of cycle t (called at its falling edge), then advances.
    task automatic cycle();
        int         c, i;
        logic [7:0] es;
        logic [3:0] ec;
        logic       suppress;
        if (t % FRAME == 0) begin
            s_digits = digits;
            s_dp     = dp;
            s_blank  = blank;
            s_lzb    = lzb_en;
        end
        c  = t % DIV;
        i  = (t / DIV) % N;
        es = 8'h00;
        ec = 4'hF;
        suppress = 1'b0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        suppress = s_lzb && (i >= 1) && ((s_digits >> (4 * i)) == 16'h0);
`endif
        if (c >= DEAD) begin
            ec = ~(4'b0001 << i);
            if (!s_blank[i]) begin
                es = suppress ? 8'h00 : glyph[(s_digits >> (4 * i)) & 16'hF];
                es = es | {7'b0, s_dp[i]};
            end
        end
        check("seg",     seg_data,                   es);
        check("com",     seg_com,                    ec);
        check("tick",    frame_tick,                 (t % FRAME) == FRAME - 1);
        check("one_com", $countones(~seg_com) <= 1,  1);
        @(posedge clk);
        @(negedge clk);
        t++;
    endtask

    initial begin
        // Reset held for five cycles
        repeat (5) begin
            @(negedge clk);
            check_dark("reset");
        end
        rst_n = 1'b1;
        t     = 0;

        // Full scan of a fixed pattern over two frames
        digits = 16'h3A09;
        dp     = 4'b0010;
        repeat (2 * FRAME) cycle();

        // Mid-frame input change must not tear the current frame
        digits = 16'h1111;
        dp     = 4'b0000;
        repeat (2 * DIV) cycle();
        digits = 16'h2222;
        repeat (2 * DIV + FRAME) cycle();

        // Blanked digit, then async reset at slot 3, cnt 5
        blank = 4'b0100;
        repeat (FRAME + 3 * DIV + 5) cycle();
        rst_n = 1'b0;
        #1;
        check_dark("async_rst");
        repeat (3) begin
            @(negedge clk);
            check_dark("rst_hold");
        end
        rst_n = 1'b1;
        t     = 0;
        repeat (FRAME) cycle();
        blank = 4'b0000;

        // Randomized inputs changing at random times
        repeat (20 * FRAME) begin
            if ($urandom_range(0, 5) == 0) begin
                digits = 16'($urandom);
                dp     = 4'($urandom);
                blank  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
                lzb_en = 1'($urandom);
            end
            cycle();
        end

        // Leading-zero cases (plain display when the feature is compiled out)
        while (t % FRAME != 0) cycle();
        blank  = 4'b0000;
        dp     = 4'b0000;
        lzb_en = 1'b1;
        digits = 16'h0050;
        repeat (FRAME) cycle();
        digits = 16'h0000;
        repeat (FRAME) cycle();
        dp = 4'b1000;
        repeat (FRAME) cycle();
        lzb_en = 1'b0;
        repeat (FRAME) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
